// File: rtl/branch_pkg.sv
// Shared definitions for the conditional-branch unit: opcodes, flush FSM states
// and the pattern-history-table reset value.
package branch_pkg;

    localparam logic [4:0] OP_BZ  = 5'b10100;
    localparam logic [4:0] OP_BNZ = 5'b10101;
    localparam logic [4:0] OP_BC  = 5'b10110;
    localparam logic [4:0] OP_BNC = 5'b10111;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } flush_state_t;

    // Weakly not-taken
    localparam logic [1:0] PHT_INIT = 2'b01;

    function automatic logic isBranchOp(input logic [4:0] op);
        return (op == OP_BZ) || (op == OP_BNZ) || (op == OP_BC) || (op == OP_BNC);
    endfunction

endpackage

// File: rtl/sat_counter2.sv
// Two-bit saturating up/down counter; one instance per pattern-history-table entry.
module sat_counter2
    import branch_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       inc,
    output logic [1:0] count
);

    logic [1:0] countReg;

    always_ff @(posedge clk) begin
        if (rst) begin
            countReg <= PHT_INIT;
        end else if (en) begin
            if (inc && (countReg != 2'b11)) begin
                countReg <= countReg + 2'd1;
            end else if (!inc && (countReg != 2'b00)) begin
                countReg <= countReg - 2'd1;
            end
        end
    end

    assign count = countReg;

endmodule

// File: rtl/branch_unit.sv
// Conditional-branch unit: C/Z flag register, PHT direction predictor,
// EX-stage branch resolution, timed flush on mispredict and statistics.
module branch_unit
    import branch_pkg::*;
#(
    parameter int OPC_W        = 5,
    parameter int PC_W         = 12,
    parameter int PHT_DEPTH    = 16,
    parameter int FLUSH_CYCLES = 2,
    parameter bit PREDICT_EN   = 1'b1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PC_W-1:0]  if_pc,
    output logic             if_pred_taken,
    input  logic             flag_we,
    input  logic             c_in,
    input  logic             z_in,
    input  logic             ex_valid,
    input  logic [OPC_W-1:0] ex_opcode,
    input  logic [PC_W-1:0]  ex_pc,
    input  logic             ex_pred_taken,
    input  logic [PC_W-1:0]  ex_target,
    output logic             br_taken,
    output logic             mispredict,
    output logic [PC_W-1:0]  redirect_pc,
    output logic             flush,
    output logic [1:0]       flags_q,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] mp_cnt
);

    localparam int IDX_W = $clog2(PHT_DEPTH);
    localparam int FC_W  = $clog2(FLUSH_CYCLES + 1);

    logic [1:0]       flagsReg;
    logic             effC;
    logic             effZ;
    logic             isBranch;
    logic             condTrue;
    logic             resolve;
    flush_state_t     stateReg;
    flush_state_t     stateNext;
    logic [FC_W-1:0]  flushCntReg;
    logic [FC_W-1:0]  flushCntNext;
    logic [CNT_W-1:0] brCntReg;
    logic [CNT_W-1:0] mpCntReg;
    logic [1:0]       phtCount [PHT_DEPTH];
    logic [IDX_W-1:0] exIdx;
    logic [IDX_W-1:0] ifIdx;
    logic             unusedPcBits;

    // Same-cycle bypass lets a branch see flags written by the instruction ahead of it
    assign effC = flag_we ? c_in : flagsReg[1];
    assign effZ = flag_we ? z_in : flagsReg[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            flagsReg <= 2'b00;
        end else if (flag_we) begin
            flagsReg <= {c_in, z_in};
        end
    end

    assign isBranch = ((ex_opcode >> 5) == '0) && isBranchOp(ex_opcode[4:0]);

    always_comb begin
        condTrue = 1'b0;
        case (ex_opcode[4:0])
            OP_BZ:   condTrue = effZ;
            OP_BNZ:  condTrue = !effZ;
            OP_BC:   condTrue = effC;
            OP_BNC:  condTrue = !effC;
            default: condTrue = 1'b0;
        endcase
    end

    assign resolve     = ex_valid && isBranch && (stateReg == IDLE);
    assign br_taken    = resolve && condTrue;
    assign mispredict  = resolve && (condTrue ^ ex_pred_taken);
    assign redirect_pc = condTrue ? ex_target : (ex_pc + PC_W'(1));

    assign exIdx = ex_pc[IDX_W-1:0];
    assign ifIdx = if_pc[IDX_W-1:0];
    assign unusedPcBits = ^{if_pc, ex_pc};

    generate
        for (genvar gi = 0; gi < PHT_DEPTH; gi++) begin : gen_pht
            if (PREDICT_EN) begin : gen_cnt
                sat_counter2 u_cnt (
                    .clk   (clk),
                    .rst   (rst),
                    .en    (resolve && (exIdx == IDX_W'(gi))),
                    .inc   (condTrue),
                    .count (phtCount[gi])
                );
            end else begin : gen_const
                assign phtCount[gi] = PHT_INIT;
            end
        end
    endgenerate

    assign if_pred_taken = PREDICT_EN ? phtCount[ifIdx][1] : 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg    <= IDLE;
            flushCntReg <= '0;
        end else begin
            stateReg    <= stateNext;
            flushCntReg <= flushCntNext;
        end
    end

    // Down-counter is loaded with the full length so FLUSH lasts exactly FLUSH_CYCLES
    always_comb begin
        stateNext    = stateReg;
        flushCntNext = flushCntReg;
        flush        = 1'b0;
        case (stateReg)
            IDLE: begin
                if (mispredict) begin
                    stateNext    = FLUSH;
                    flushCntNext = FC_W'(FLUSH_CYCLES);
                end
            end
            FLUSH: begin
                flush        = 1'b1;
                flushCntNext = flushCntReg - FC_W'(1);
                if (flushCntReg == FC_W'(1)) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            brCntReg <= '0;
            mpCntReg <= '0;
        end else begin
            if (resolve && (brCntReg != '1)) begin
                brCntReg <= brCntReg + CNT_W'(1);
            end
            if (mispredict && (mpCntReg != '1)) begin
                mpCntReg <= mpCntReg + CNT_W'(1);
            end
        end
    end

    assign flags_q = flagsReg;
    assign br_cnt  = brCntReg;
    assign mp_cnt  = mpCntReg;

endmodule

// File: tb/tb_branch_unit.sv
// Scoreboard bench for branch_unit: a driver issues one cycle of stimulus and pushes
// the reference model's expectations; a monitor pops and compares mid-cycle.
module tb_branch_unit;

    localparam int OPC_W        = 5;
    localparam int PC_W         = 12;
    localparam int PHT_DEPTH    = 16;
    localparam int FLUSH_CYCLES = 2;
    localparam int CNT_W        = 4;
    localparam int CNT_MAX      = 15;

    logic             clk;
    logic             rst;
    logic [PC_W-1:0]  if_pc;
    logic             if_pred_taken;
    logic             flag_we;
    logic             c_in;
    logic             z_in;
    logic             ex_valid;
    logic [OPC_W-1:0] ex_opcode;
    logic [PC_W-1:0]  ex_pc;
    logic             ex_pred_taken;
    logic [PC_W-1:0]  ex_target;
    logic             br_taken;
    logic             mispredict;
    logic [PC_W-1:0]  redirect_pc;
    logic             flush;
    logic [1:0]       flags_q;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] mp_cnt;

    branch_unit #(
        .OPC_W        (OPC_W),
        .PC_W         (PC_W),
        .PHT_DEPTH    (PHT_DEPTH),
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .PREDICT_EN   (1'b1),
        .CNT_W        (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .if_pc         (if_pc),
        .if_pred_taken (if_pred_taken),
        .flag_we       (flag_we),
        .c_in          (c_in),
        .z_in          (z_in),
        .ex_valid      (ex_valid),
        .ex_opcode     (ex_opcode),
        .ex_pc         (ex_pc),
        .ex_pred_taken (ex_pred_taken),
        .ex_target     (ex_target),
        .br_taken      (br_taken),
        .mispredict    (mispredict),
        .redirect_pc   (redirect_pc),
        .flush         (flush),
        .flags_q       (flags_q),
        .br_cnt        (br_cnt),
        .mp_cnt        (mp_cnt)
    );

    typedef struct {
        int               id;
        logic [4:0]       op;
        logic [PC_W-1:0]  pc;
        logic             predTaken;
        logic             brTaken;
        logic             mispredict;
        logic [PC_W-1:0]  redirect;
        logic             checkRedirect;
        logic             flush;
        logic [1:0]       flags;
        logic [CNT_W-1:0] brCnt;
        logic [CNT_W-1:0] mpCnt;
        logic             resolved;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    int   txnId  = 0;

    // Reference model state
    int pht [PHT_DEPTH];
    bit mC, mZ;
    int flushLeft;
    int mBr, mMp;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want, input int id);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s txn %0d got %0h expected %0h", name, id, got, want);
        end
    endtask

    task automatic drive(input bit r, input bit fwe, input bit c, input bit z, input bit v,
                         input logic [4:0] op, input logic [PC_W-1:0] pc, input logic [PC_W-1:0] tgt,
                         input logic [PC_W-1:0] ipc, input bit pt, input bit doCheck);
        exp_t e;
        bit   cf, zf, isBr, cond, res;
        int   idx;
        @(negedge clk);
        rst = r; flag_we = fwe; c_in = c; z_in = z; ex_valid = v;
        ex_opcode = op; ex_pc = pc; ex_target = tgt; if_pc = ipc; ex_pred_taken = pt;

        e.id        = txnId++;
        e.op        = op;
        e.pc        = pc;
        e.predTaken = (pht[int'(ipc[3:0])] >= 2);
        e.flush     = (flushLeft > 0);
        e.flags     = {mC, mZ};
        e.brCnt     = CNT_W'(mBr);
        e.mpCnt     = CNT_W'(mMp);
        cf   = fwe ? c : mC;
        zf   = fwe ? z : mZ;
        isBr = (op >= 5'd20) && (op <= 5'd23);
        case (op)
            5'd20:   cond = zf;
            5'd21:   cond = !zf;
            5'd22:   cond = cf;
            5'd23:   cond = !cf;
            default: cond = 1'b0;
        endcase
        res = v && isBr && (flushLeft == 0);
        e.resolved      = res;
        e.brTaken       = res && cond;
        e.mispredict    = res && (cond != pt);
        e.redirect      = cond ? tgt : PC_W'((int'(pc) + 1) % (1 << PC_W));
        e.checkRedirect = e.mispredict;
        if (doCheck) expQ.push_back(e);

        if (r) begin
            foreach (pht[i]) pht[i] = 1;
            mC = 0; mZ = 0; flushLeft = 0; mBr = 0; mMp = 0;
        end else begin
            if (fwe) begin
                mC = c; mZ = z;
            end
            if (flushLeft > 0) flushLeft--;
            else if (e.mispredict) flushLeft = FLUSH_CYCLES;
            if (res) begin
                idx = int'(pc[3:0]);
                if (cond) pht[idx] = (pht[idx] < 3) ? pht[idx] + 1 : 3;
                else      pht[idx] = (pht[idx] > 0) ? pht[idx] - 1 : 0;
                if (mBr < CNT_MAX) mBr++;
                if (e.mispredict && (mMp < CNT_MAX)) mMp++;
            end
        end
    endtask

    task automatic idle(input logic [PC_W-1:0] ipc);
        drive(0, 0, 0, 0, 0, 5'd0, '0, '0, ipc, 0, 1);
    endtask

    // Monitor: compares every queued expectation against the DUT mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            while (expQ.size() > 0) begin
                e = expQ.pop_front();
                chk("if_pred_taken", 32'(if_pred_taken), 32'(e.predTaken), e.id);
                chk("br_taken", 32'(br_taken), 32'(e.brTaken), e.id);
                chk("mispredict", 32'(mispredict), 32'(e.mispredict), e.id);
                if (e.checkRedirect) chk("redirect_pc", 32'(redirect_pc), 32'(e.redirect), e.id);
                chk("flush", 32'(flush), 32'(e.flush), e.id);
                chk("flags_q", 32'(flags_q), 32'(e.flags), e.id);
                chk("br_cnt", 32'(br_cnt), 32'(e.brCnt), e.id);
                chk("mp_cnt", 32'(mp_cnt), 32'(e.mpCnt), e.id);
                if (e.resolved)
                    $display("txn %0d op=%0h pc=%0h taken=%0b mispredict=%0b br_cnt=%0d mp_cnt=%0d",
                             e.id, e.op, e.pc, br_taken, mispredict, br_cnt, mp_cnt);
            end
        end
    end

    initial begin
        logic [4:0] op;
        int         waitCycles;
        rst = 1'b1; flag_we = 0; c_in = 0; z_in = 0; ex_valid = 0;
        ex_opcode = '0; ex_pc = '0; ex_target = '0; if_pc = '0; ex_pred_taken = 0;

        drive(1, 0, 0, 0, 0, 5'd0, '0, '0, 12'd3, 0, 0);
        drive(1, 0, 0, 0, 0, 5'd0, '0, '0, 12'd3, 0, 0);

        // Reset state
        idle(12'd3);

        // Mispredict with same-cycle flag bypass, then a branch ignored during flush
        drive(0, 1, 0, 1, 1, 5'b10100, 12'h010, 12'h040, 12'd3, 0, 1);
        drive(0, 0, 0, 0, 1, 5'b10100, 12'd5, 12'h080, 12'd5, 0, 1);
        idle(12'd5);
        idle(12'd5);

        // Training entry 5 with BNC (C=0): taken twice, lookup collides with update
        drive(0, 0, 0, 0, 1, 5'b10111, 12'd5, 12'h100, 12'd5, 1, 1);
        idle(12'd5);
        drive(0, 0, 0, 0, 1, 5'b10111, 12'd5, 12'h100, 12'd5, 1, 1);
        idle(12'd5);
        // Back down with C=1 via bypass
        drive(0, 1, 1, 1, 1, 5'b10111, 12'd5, 12'h100, 12'd5, 0, 1);
        idle(12'd5);
        drive(0, 1, 1, 1, 1, 5'b10111, 12'd5, 12'h100, 12'd5, 1, 1);
        idle(12'd5);
        idle(12'd5);

        // Reset on the first flush cycle
        drive(0, 1, 1, 0, 1, 5'b10110, 12'hFFF, 12'h200, 12'd5, 0, 1);
        drive(1, 0, 0, 0, 0, 5'd0, '0, '0, 12'd5, 0, 1);
        idle(12'd5);

        // Non-branch opcode
        drive(0, 0, 0, 0, 1, 5'b00011, 12'd7, 12'h300, 12'd7, 1, 1);
        idle(12'd7);

        // Randomised traffic, small PC range on some cycles to exercise PHT reuse
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) < 7) op = 5'(20 + $urandom_range(0, 3));
            else                          op = 5'($urandom_range(0, 31));
            drive(($urandom_range(0, 79) == 0), ($urandom_range(0, 2) == 0),
                  1'($urandom), 1'($urandom), ($urandom_range(0, 6) != 0), op,
                  ($urandom_range(0, 1) == 1) ? PC_W'($urandom_range(0, 7)) : PC_W'($urandom),
                  PC_W'($urandom),
                  ($urandom_range(0, 1) == 1) ? PC_W'($urandom_range(0, 7)) : PC_W'($urandom),
                  1'($urandom), 1);
        end

        waitCycles = 0;
        while ((expQ.size() > 0) && (waitCycles < 10)) begin
            @(negedge clk);
            waitCycles++;
        end
        repeat (2) @(negedge clk);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending expected 0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_unit.md
# branch_unit

Parametrised conditional-branch unit for the pipelined core, successor to the combinational flag check. It does four things:
- holds the architectural C/Z flag register;
- predicts branch direction in IF using a table of 2-bit saturating counters (pattern history table, PHT);
- resolves the four conditional branches in EX against the flags;
- on a misprediction, drives a timed pipeline flush and a redirect, and keeps saturating branch and misprediction counters.

## Interface
Parameters:
- `OPC_W`, 5: opcode width. Branch opcodes occupy the low 5 bits; higher bits must be zero.
- `PC_W`, 12: PC width.
- `PHT_DEPTH`, 16: number of PHT entries, power of 2, ≥2. Index is `pc[log2(PHT_DEPTH)-1:0]`.
- `FLUSH_CYCLES`, 2: cycles `flush` stays high after a mispredict, ≥1.
- `PREDICT_EN`, 1: when 0, prediction is always not-taken and the PHT is never written.
- `CNT_W`, 16: width of the statistics counters.

Ports:
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `if_pc`, in, `PC_W`: PC of the instruction being fetched.
- `if_pred_taken`, out, 1: prediction for `if_pc`. Combinational read of the PHT.
- `flag_we`, in, 1: ALU flag write enable.
- `c_in`, in, 1: carry from the ALU.
- `z_in`, in, 1: zero from the ALU.
- `ex_valid`, in, 1: the EX instruction is valid.
- `ex_opcode`, in, `OPC_W`: opcode of the EX instruction.
- `ex_pc`, in, `PC_W`: PC of the EX instruction.
- `ex_pred_taken`, in, 1: prediction carried down the pipe with the instruction.
- `ex_target`, in, `PC_W`: branch target address.
- `br_taken`, out, 1: actual branch outcome. Combinational.
- `mispredict`, out, 1: outcome differs from the carried prediction. Combinational.
- `redirect_pc`, out, `PC_W`: correct next PC. Valid while `mispredict` is high.
- `flush`, out, 1: registered flush request to IF/ID.
- `flags_q`, out, 2: `{C,Z}` flag register.
- `br_cnt`, out, `CNT_W`: number of branches resolved.
- `mp_cnt`, out, `CNT_W`: number of mispredicts.

## Operation
- Opcodes and conditions:
  - BZ `10100`: taken if Z.
  - BNZ `10101`: taken if !Z.
  - BC `10110`: taken if C.
  - BNC `10111`: taken if !C.
  - Any other opcode is not a branch: `br_taken` = 0 and `mispredict` = 0.
- Effective flags used for resolution:
  - if `flag_we` is high, `{c_in,z_in}` (same-cycle bypass);
  - otherwise `flags_q`.
- The flag register loads `{c_in,z_in}` at the clock edge when `flag_we` is high, regardless of the flush state.
- A resolve event happens when `ex_valid` is high, the opcode is a branch, and the state is IDLE.
- On a resolve event:
  - `mispredict` = `br_taken` ^ `ex_pred_taken`.
  - `redirect_pc` = `ex_target` if taken, else `ex_pc+1` (wraps modulo 2^`PC_W`).
- PHT update on a resolve event with `PREDICT_EN` = 1:
  - the counter at index `ex_pc` increments if taken, decrements if not;
  - it saturates at 3 and 0.
- Prediction: `if_pred_taken` = counter[1] of the entry indexed by `if_pc`.
- Flush FSM:
  - **IDLE**: `flush` = 0. A mispredict moves to FLUSH and loads the down-counter with `FLUSH_CYCLES`.
  - **FLUSH**: `flush` = 1. The counter decrements each cycle and the FSM returns to IDLE when the counter reaches 1.
  - While in FLUSH, EX inputs are ignored: no resolve, no PHT write, no counter increment, and `br_taken` = `mispredict` = 0.
- Statistics counters:
  - `br_cnt` increments on every resolve event;
  - `mp_cnt` increments on every mispredict;
  - both saturate at all-ones and do not wrap.
- Reset values:
  - every PHT entry = `01` (weakly not-taken);
  - `flags_q` = 0;
  - `flush` = 0, FSM in IDLE;
  - `br_cnt` = `mp_cnt` = 0.

## Timing
- `br_taken`, `mispredict`, `redirect_pc` and `if_pred_taken` are combinational, with zero-cycle latency.
- `flush` rises on the edge after the mispredict cycle and stays high for exactly `FLUSH_CYCLES` cycles.
- PHT reads are read-before-write: a same-cycle lookup and update of the same index returns the old counter. The new value is visible the next cycle.
- Flag write and branch resolve in the same cycle: the branch uses the new flags through the bypass.
- `rst` asserted during FLUSH: the next cycle is IDLE with `flush` = 0, and the PHT and counters return to their reset values.
- `rst` has priority over every other event in the same cycle.

## Structure
- Shared package `branch_pkg`:
  - opcode constants `OP_BZ`, `OP_BNZ`, `OP_BC`, `OP_BNC`;
  - enum `flush_state_t` {IDLE, FLUSH};
  - PHT reset constant `PHT_INIT = 2'b01`.
- One sub-module, `sat_counter2`: a 2-bit saturating counter with inc/dec/enable, replicated `PHT_DEPTH` times by a generate loop.
- The top level holds the flags, resolve logic, FSM and statistics.

## Test plan
- **Reset:** after reset, `if_pc`=3 → `if_pred_taken`=0, `flags_q`=00, `flush`=0, both counters 0.
- **Misprediction:** `flag_we`=1, `z_in`=1 in the same cycle as BZ with `ex_pred_taken`=0 and `ex_target`=0x040 → `br_taken`=1, `mispredict`=1, `redirect_pc`=0x040. `flush` is high for the next 2 cycles, then low. `br_cnt`=1, `mp_cnt`=1.
- **Training:** BNC at `ex_pc`=5 with C=0, resolved twice (with an IDLE gap between) → entry 5 goes 01→10→11 and `if_pc`=5 predicts taken. Resolving 2 not-taken returns it to 01.
- **Ignored during flush:** a branch presented while `flush` is high → no PHT change, counters unchanged, `mispredict`=0.
- **Saturation and disabled prediction:** `CNT_W`=4 with 20 mispredicts → `mp_cnt` holds at 15. With `PREDICT_EN`=0, `if_pred_taken` is always 0 and entries stay 01.
- **Reset mid-flush:** `rst` on the first FLUSH cycle with `FLUSH_CYCLES`=4 → `flush`=0 on the next cycle. Non-branch opcode `00011` with `ex_valid` → `br_taken`=0, `br_cnt` unchanged.
